nibble_serial_adder: RTL and testbench

//  Multi-word adder that feeds a 4-bit ripple add stage one nibble per cycle.

---
 rtl/nibble_serial_adder_pkg.sv | 20 ++
 rtl/nibble_serial_adder_add4.sv | 24 ++
 rtl/nibble_serial_adder.sv | 156 +++++++++++++++
 tb/tb_nibble_serial_adder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_serial_adder_pkg
//  Purpose  : Shared definitions for the nibble-serial adder: the controller
//             state encoding and the width of one add step.
//  Revision : 1.0  initial release
// ============================================================================
package nibble_serial_adder_pkg;

    // Width of the single ripple add stage; operands are walked in slices of this size.
    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : nibble_serial_adder_pkg
`default_nettype wire

// File: rtl/nibble_serial_adder_add4.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_add4
//  Purpose  : Combinational 4-bit adder with carry-in and carry-out.
//  Ports    : a4, b4 - nibble operands
//             ci     - carry in
//             s4     - nibble sum
//             co     - carry out
//  Revision : 1.0  initial release
// ============================================================================
module nibble_add4
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a4,
    input  logic [NIBBLE_W-1:0] b4,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s4,
    output logic                co
);

    assign {co, s4} = {1'b0, a4} + {1'b0, b4} + {{NIBBLE_W{1'b0}}, ci};

endmodule : nibble_add4
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_serial_adder
//  Purpose  : WIDTH-bit adder built from one 4-bit add stage that is reused
//             once per nibble, low nibble first, with the carry chained
//             through a register. Operands arrive and the result leaves over
//             valid/ready handshakes; one operation is in flight at a time.
//  Ports    : clk, rst_n            - clock, async active-low reset
//             in_valid/in_ready     - operand handshake (a, b, cin)
//             out_valid/out_ready   - result handshake (sum, cout)
//  Revision : 1.0  initial release
// ============================================================================
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NIB      = WIDTH / NIBBLE_W;
    localparam int CNT_W    = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);

    generate
        if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_check
            $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    state_t r_state;
    state_t w_next_state;

    // Operands and result are held as nibble arrays so the active slice is a
    // plain index by the counter.
    logic [NIB-1:0][NIBBLE_W-1:0] r_a;
    logic [NIB-1:0][NIBBLE_W-1:0] r_b;
    logic [NIB-1:0][NIBBLE_W-1:0] r_sum;
    logic [CNT_W-1:0]             r_cnt;
    logic                         r_carry;
    logic                         r_cout;

    logic [NIBBLE_W-1:0]          w_a_nib;
    logic [NIBBLE_W-1:0]          w_b_nib;
    logic [NIBBLE_W-1:0]          w_s4;
    logic                         w_co;
    logic                         w_last;

    assign w_a_nib = r_a[r_cnt];
    assign w_b_nib = r_b[r_cnt];
    assign w_last  = (r_cnt == CNT_LAST);

    nibble_add4 u_add4 (
        .a4 (w_a_nib),
        .b4 (w_b_nib),
        .ci (r_carry),
        .s4 (w_s4),
        .co (w_co)
    );

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Handshake outputs are decoded from the state register, so an
    // asynchronous reset drops out_valid and raises in_ready at once.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_sum[r_cnt] <= w_s4;
                    r_carry      <= w_co;
                    // Counter parks on the last nibble instead of wrapping.
                    if (w_last) begin
                        r_cout <= w_co;
                    end else begin
                        r_cnt  <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    // DONE holds the result until the consumer takes it.
                end
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule : nibble_serial_adder
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nibble_serial_adder
//  Purpose  : Self-checking bench for nibble_serial_adder at WIDTH 16, 4, 32.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nibble_serial_adder;

    logic clk;
    logic rst_n;

    int errors;
    int checks;

    // WIDTH=16 instance
    logic        in_valid16, in_ready16, out_valid16, out_ready16, cin16, cout16;
    logic [15:0] a16, b16, sum16;
    // WIDTH=4 instance
    logic        in_valid4, in_ready4, out_valid4, out_ready4, cin4, cout4;
    logic [3:0]  a4, b4, sum4;
    // WIDTH=32 instance
    logic        in_valid32, in_ready32, out_valid32, out_ready32, cin32, cout32;
    logic [31:0] a32, b32, sum32;

    nibble_serial_adder #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .cin(cin16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .sum(sum16), .cout(cout16)
    );

    nibble_serial_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4)
    );

    nibble_serial_adder #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .cin(cin32),
        .out_valid(out_valid32), .out_ready(out_ready32),
        .sum(sum32), .cout(cout32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=16 operation: hold = cycles to stall in DONE with in_valid
    // toggling; scramble = change the operand inputs every cycle while busy.
    task automatic run16(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                         input int hold, input bit scramble);
        logic [16:0] exp;
        int          lat;
        exp = {1'b0, ta} + {1'b0, tb} + {16'd0, tc};
        chk("idle_ready", in_ready16, 1);
        a16 = ta; b16 = tb; cin16 = tc;
        in_valid16 = 1'b1; out_ready16 = 1'b0;
        tick();
        in_valid16 = 1'b0;
        lat = 1;
        chk("busy_ready", in_ready16, 0);
        while (out_valid16 !== 1'b1 && lat < 20) begin
            if (scramble) begin
                a16 = 16'($urandom); b16 = 16'($urandom);
                cin16 = 1'($urandom); in_valid16 = 1'($urandom);
            end
            tick();
            lat++;
        end
        chk("latency", 64'(lat), 64'd5);
        for (int i = 0; i < hold; i++) begin
            in_valid16 = ~in_valid16;
            a16 = 16'($urandom); b16 = 16'($urandom);
            tick();
            chk("hold_result", {cout16, sum16}, exp);
            chk("hold_in_ready", in_ready16, 0);
            chk("hold_out_valid", out_valid16, 1);
        end
        chk("result", {cout16, sum16}, exp);
        out_ready16 = 1'b1;
        tick();
        out_ready16 = 1'b0;
        in_valid16 = 1'b0;
        chk("out_valid_clear", out_valid16, 0);
        chk("ready_back", in_ready16, 1);
    endtask

    logic [63:0] q4[$];
    logic [63:0] q32[$];

    initial begin
        int done;
        int cyc;
        logic [63:0] exp;

        errors = 0; checks = 0;
        rst_n = 1'b0;
        in_valid16 = 0; out_ready16 = 0; a16 = 0; b16 = 0; cin16 = 0;
        in_valid4  = 0; out_ready4  = 0; a4  = 0; b4  = 0; cin4  = 0;
        in_valid32 = 0; out_ready32 = 0; a32 = 0; b32 = 0; cin32 = 0;

        tick(); tick();
        chk("rst_in_ready", in_ready16, 1);
        chk("rst_out_valid", out_valid16, 0);
        chk("rst_sum", sum16, 0);
        chk("rst_cout", cout16, 0);
        #2 rst_n = 1'b1;
        tick();

        // Directed operations
        run16(16'h00FF, 16'h0001, 1'b0, 0, 1'b0);
        run16(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
        run16(16'hFFFF, 16'h0000, 1'b1, 6, 1'b0);
        run16(16'h1234, 16'hABCD, 1'b1, 0, 1'b1);
        run16(16'h8000, 16'h8000, 1'b0, 2, 1'b1);
        for (int i = 0; i < 4; i++) begin
            run16(16'($urandom), 16'($urandom), 1'($urandom), i, 1'b1);
        end

        // Asynchronous reset while the third nibble is being added
        a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b1; in_valid16 = 1'b1;
        tick();                 // accept
        in_valid16 = 1'b0;
        tick(); tick();         // counter now at 2, low nibbles written
        chk("pre_reset_sum_nonzero", (sum16 != 16'h0), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid16, 0);
        chk("arst_sum", sum16, 0);
        chk("arst_cout", cout16, 0);
        chk("arst_in_ready", in_ready16, 1);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_reset_no_result", out_valid16, 0);
        end
        run16(16'h0F0F, 16'hF0F1, 1'b0, 1, 1'b0);

        // Random traffic, WIDTH=4
        done = 0; cyc = 0;
        while (done < 1500 && cyc < 40000) begin
            in_valid4 = 1'($urandom); out_ready4 = 1'($urandom);
            a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
            if (in_valid4 && in_ready4) begin
                q4.push_back(64'(a4) + 64'(b4) + 64'(cin4));
            end
            if (out_valid4 && out_ready4) begin
                if (q4.size() == 0) begin
                    chk("w4_spurious_result", 1, 0);
                end else begin
                    exp = q4.pop_front();
                    chk("w4_result", {cout4, sum4}, exp);
                end
                done++;
            end
            tick();
            cyc++;
        end
        chk("w4_ops_completed", 64'(done), 64'd1500);
        in_valid4 = 1'b0; out_ready4 = 1'b0;

        // Random traffic, WIDTH=32
        done = 0; cyc = 0;
        while (done < 1500 && cyc < 60000) begin
            in_valid32 = 1'($urandom); out_ready32 = 1'($urandom);
            a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom);
            if (in_valid32 && in_ready32) begin
                q32.push_back(64'(a32) + 64'(b32) + 64'(cin32));
            end
            if (out_valid32 && out_ready32) begin
                if (q32.size() == 0) begin
                    chk("w32_spurious_result", 1, 0);
                end else begin
                    exp = q32.pop_front();
                    chk("w32_result", {cout32, sum32}, exp);
                end
                done++;
            end
            tick();
            cyc++;
        end
        chk("w32_ops_completed", 64'(done), 64'd1500);
        in_valid32 = 1'b0; out_ready32 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_nibble_serial_adder
`default_nettype wire
